// File: rtl/aes_inv_round_engine.sv
// Iterative AES inverse cipher: one shared inverse round reused NR times, with
// valid/ready on both streams and an indexed round-key fetch port.
module aes_inv_round_engine #(
  parameter int NR     = 10,
  parameter int KIDX_W = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [0:127]      in_data_i,
  output logic [KIDX_W-1:0] key_idx_o,
  input  logic [0:127]      round_key_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [0:127]      out_data_o,
  output logic              busy_o
);

  generate
    if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
      $error("aes_inv_round_engine: NR must be 10, 12 or 14");
    end
    if ((1 << KIDX_W) <= NR) begin : g_bad_kidx
      $error("aes_inv_round_engine: KIDX_W too narrow to index round key NR");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRST,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_t;

  localparam logic [KIDX_W-1:0] KIDX_LAST  = KIDX_W'(NR);
  localparam logic [KIDX_W-1:0] KIDX_ROUND = KIDX_W'(NR - 1);
  localparam logic [KIDX_W-1:0] KIDX_ONE   = KIDX_W'(1);

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiples 9/11/13/14 built from the x2/x4/x8 chain, byte 0 in col[31:24].
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a   [4];
    logic [7:0] m9  [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]   = col[31-8*i -: 8];
      x2     = xtime(a[i]);
      x4     = xtime(x2);
      x8     = xtime(x4);
      m9[i]  = x8 ^ a[i];
      m11[i] = x8 ^ x2 ^ a[i];
      m13[i] = x8 ^ x4 ^ a[i];
      m14[i] = x8 ^ x4 ^ x2;
    end
    return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
            m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
            m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
            m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
  endfunction

  state_t              state_q, state_d;
  logic [0:127]        st_q, st_d;
  logic [KIDX_W-1:0]   key_idx_q, key_idx_d;
  logic                out_valid_q, out_valid_d;
  logic [0:127]        out_data_q, out_data_d;

  logic [0:127]        ark;
  logic [0:127]        imc;
  logic [0:127]        mix_sel;
  logic [0:127]        isr;
  logic [0:127]        isb;

  assign ark     = st_q ^ round_key_i;
  assign mix_sel = (state_q == S_ROUND) ? imc : ark;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_col
      assign imc[32*gi +: 32] = inv_mix_col(ark[32*gi +: 32]);
    end
    // Row r of the column-major state rotates right by r positions.
    for (gi = 0; gi < 16; gi++) begin : g_byte
      localparam int ROW = gi % 4;
      localparam int COL = gi / 4;
      localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;
      assign isr[8*gi +: 8] = mix_sel[8*SRC +: 8];
      assign isb[8*gi +: 8] = INV_SBOX[isr[8*gi +: 8]];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    st_d        = st_q;
    key_idx_d   = key_idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          st_d      = in_data_i;
          key_idx_d = KIDX_LAST;
          state_d   = S_FIRST;
        end
      end
      S_FIRST: begin
        st_d      = isb;
        key_idx_d = KIDX_ROUND;
        state_d   = S_ROUND;
      end
      S_ROUND: begin
        st_d = isb;
        if (key_idx_q == KIDX_ONE) begin
          key_idx_d = '0;
          state_d   = S_FINAL;
        end else begin
          key_idx_d = key_idx_q - KIDX_ONE;
        end
      end
      S_FINAL: begin
        out_data_d  = ark;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          key_idx_d   = '0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      st_q        <= '0;
      key_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      key_idx_q   <= key_idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign key_idx_o   = key_idx_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: tb/tb_aes_inv_round_engine.sv
// Bench for aes_inv_round_engine: FIPS-197 C.1/C.2/C.3 vectors with a key-schedule
// model driving round_key, scoreboard queue of expected plaintexts and latencies.
module tb_aes_inv_round_engine;

  localparam logic [0:127] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] CT2 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [0:127] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [0:127] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:255] K1  = 256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000;
  localparam logic [0:255] K2  = 256'h000102030405060708090a0b0c0d0e0f1011121314151617_0000000000000000;
  localparam logic [0:255] K3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  typedef struct {
    logic [0:127] data;
    int           acc;
    int           nr;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;

  logic         in_valid = 1'b0;
  logic [0:127] in_data = '0;
  logic         out_ready = 1'b1;
  logic         in_ready, out_valid, busy;
  logic [3:0]   kidx;
  logic [0:127] out_data, rk10;

  logic         in_valid12 = 1'b0;
  logic [0:127] in_data12 = '0;
  logic         out_ready12 = 1'b1;
  logic         in_ready12, out_valid12, busy12;
  logic [3:0]   kidx12;
  logic [0:127] out_data12, rk12;

  logic         in_valid14 = 1'b0;
  logic [0:127] in_data14 = '0;
  logic         out_ready14 = 1'b1;
  logic         in_ready14, out_valid14, busy14;
  logic [3:0]   kidx14;
  logic [0:127] out_data14, rk14;

  logic [7:0]   sbox_t [256];
  logic [0:127] ks10 [16];
  logic [0:127] ks12 [16];
  logic [0:127] ks14 [16];
  exp_t         sb [$];
  int           tests = 0;
  int           fails = 0;
  int           cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rk10 = ks10[kidx];
  assign rk12 = ks12[kidx12];
  assign rk14 = ks14[kidx14];

  aes_inv_round_engine #(.NR(10), .KIDX_W(4)) dut10 (
    .clk_i(clk), .reset_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .key_idx_o(kidx), .round_key_i(rk10), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_data_o(out_data), .busy_o(busy));

  aes_inv_round_engine #(.NR(12), .KIDX_W(4)) dut12 (
    .clk_i(clk), .reset_i(rst), .in_valid_i(in_valid12), .in_ready_o(in_ready12),
    .in_data_i(in_data12), .key_idx_o(kidx12), .round_key_i(rk12), .out_valid_o(out_valid12),
    .out_ready_i(out_ready12), .out_data_o(out_data12), .busy_o(busy12));

  aes_inv_round_engine #(.NR(14), .KIDX_W(4)) dut14 (
    .clk_i(clk), .reset_i(rst), .in_valid_i(in_valid14), .in_ready_o(in_ready14),
    .in_data_i(in_data14), .key_idx_o(kidx14), .round_key_i(rk14), .out_valid_o(out_valid14),
    .out_ready_i(out_ready14), .out_data_o(out_data14), .busy_o(busy14));

  // Forward S-box from its algebraic definition: GF(2^8) inverse then affine map.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    if (x != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gf_mul(inv, x);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic [0:127] round_key_of(input logic [0:255] key, input int nk, input int r);
    logic [31:0] w [64];
    logic [31:0] temp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
    for (int i = nk; i <= 4 * r + 3; i++) begin
      temp = w[i-1];
      if (i % nk == 0) begin
        temp = sub_word({temp[23:0], temp[31:24]}) ^ {rc, 24'h000000};
        rc   = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        temp = sub_word(temp);
      end
      w[i] = w[i-nk] ^ temp;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests++; if (out_data !== 128'h0) begin fails++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    tests++; if (kidx !== 4'd0) begin fails++; $display("FAIL reset_key_idx: got %0d expected 0", kidx); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (in_ready12 !== 1'b1 || in_ready14 !== 1'b1) begin
      fails++; $display("FAIL reset_in_ready_nr12_14: got %b/%b expected 1/1", in_ready12, in_ready14);
    end
    rst = 1'b0;
    tick();
    tests++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL idle_after_reset: got in_ready=%b busy=%b expected 1/0", in_ready, busy);
    end
  endtask

  task automatic test_c1_trace();
    exp_t e;
    sb.delete();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = CT1;
    sb.push_back('{PT, cyc + 1, 10});
    tick();
    in_valid = 1'b0; in_data = '0;
    for (int j = 0; j <= 10; j++) begin
      if (j > 0) tick();
      tests++;
      if (kidx !== 4'(10 - j) || out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL c1_trace step %0d: got key_idx=%0d out_valid=%b in_ready=%b busy=%b expected key_idx=%0d out_valid=0 in_ready=0 busy=1",
                 j, kidx, out_valid, in_ready, busy, 10 - j);
      end
    end
    tick();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL c1_out_valid: got %b expected 1", out_valid); end
    e = sb.pop_front();
    $display("[TB] c1 block: out=%h latency=%0d", out_data, cyc - e.acc);
    tests++; if (out_data !== e.data) begin fails++; $display("FAIL c1_data: got %h expected %h", out_data, e.data); end
    tests++; if (cyc - e.acc != e.nr + 1) begin fails++; $display("FAIL c1_latency: got %0d expected %0d", cyc - e.acc, e.nr + 1); end
    tests++; if (kidx !== 4'd0) begin fails++; $display("FAIL c1_done_key_idx: got %0d expected 0", kidx); end
    tick();
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL c1_handshake: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_nr12();
    exp_t e;
    sb.delete();
    tests++; if (in_ready12 !== 1'b1) begin fails++; $display("FAIL nr12_in_ready: got %b expected 1", in_ready12); end
    in_valid12 = 1'b1; in_data12 = CT2;
    sb.push_back('{PT, cyc + 1, 12});
    tick();
    in_valid12 = 1'b0;
    tests++; if (kidx12 !== 4'd12 || busy12 !== 1'b1) begin
      fails++; $display("FAIL nr12_start: got key_idx=%0d busy=%b expected 12/1", kidx12, busy12);
    end
    for (int n = 0; n < 40 && out_valid12 !== 1'b1; n++) tick();
    tests++; if (out_valid12 !== 1'b1) begin fails++; $display("FAIL nr12_timeout: got out_valid=%b expected 1", out_valid12); end
    e = sb.pop_front();
    $display("[TB] c2 block: out=%h latency=%0d", out_data12, cyc - e.acc);
    tests++; if (out_data12 !== e.data) begin fails++; $display("FAIL nr12_data: got %h expected %h", out_data12, e.data); end
    tests++; if (cyc - e.acc != e.nr + 1) begin fails++; $display("FAIL nr12_latency: got %0d expected %0d", cyc - e.acc, e.nr + 1); end
    tick();
  endtask

  task automatic test_nr14();
    exp_t e;
    sb.delete();
    tests++; if (in_ready14 !== 1'b1) begin fails++; $display("FAIL nr14_in_ready: got %b expected 1", in_ready14); end
    in_valid14 = 1'b1; in_data14 = CT3;
    sb.push_back('{PT, cyc + 1, 14});
    tick();
    in_valid14 = 1'b0;
    tests++; if (kidx14 !== 4'd14 || busy14 !== 1'b1) begin
      fails++; $display("FAIL nr14_start: got key_idx=%0d busy=%b expected 14/1", kidx14, busy14);
    end
    for (int n = 0; n < 40 && out_valid14 !== 1'b1; n++) tick();
    tests++; if (out_valid14 !== 1'b1) begin fails++; $display("FAIL nr14_timeout: got out_valid=%b expected 1", out_valid14); end
    e = sb.pop_front();
    $display("[TB] c3 block: out=%h latency=%0d", out_data14, cyc - e.acc);
    tests++; if (out_data14 !== e.data) begin fails++; $display("FAIL nr14_data: got %h expected %h", out_data14, e.data); end
    tests++; if (cyc - e.acc != e.nr + 1) begin fails++; $display("FAIL nr14_latency: got %0d expected %0d", cyc - e.acc, e.nr + 1); end
    tick();
  endtask

  task automatic test_backpressure();
    exp_t e;
    sb.delete();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = CT1;
    sb.push_back('{PT, cyc + 1, 10});
    tick();
    in_valid = 1'b0;
    for (int n = 0; n < 40 && out_valid !== 1'b1; n++) tick();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_timeout: got out_valid=%b expected 1", out_valid); end
    e = sb.pop_front();
    $display("[TB] backpressure block: out=%h latency=%0d", out_data, cyc - e.acc);
    tests++; if (out_data !== e.data) begin fails++; $display("FAIL bp_data: got %h expected %h", out_data, e.data); end
    tests++; if (cyc - e.acc != e.nr + 1) begin fails++; $display("FAIL bp_latency: got %0d expected %0d", cyc - e.acc, e.nr + 1); end
    for (int n = 0; n < 20; n++) begin
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_data !== e.data || in_ready !== 1'b0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL bp_hold cycle %0d: got out_valid=%b out_data=%h in_ready=%b busy=%b expected 1/%h/0/1",
                 n, out_valid, out_data, in_ready, busy, e.data);
      end
    end
    out_ready = 1'b1;
    tick();
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || kidx !== 4'd0) begin
      fails++; $display("FAIL bp_release: got out_valid=%b in_ready=%b busy=%b key_idx=%0d expected 0/1/0/0",
                        out_valid, in_ready, busy, kidx);
    end
  endtask

  task automatic test_in_valid_toggle();
    exp_t e;
    sb.delete();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = CT1;
    sb.push_back('{PT, cyc + 1, 10});
    tick();
    for (int n = 0; n < 10; n++) begin
      in_valid = n[0];
      in_data = {$urandom, $urandom, $urandom, $urandom};
      tick();
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL toggle_in_ready cycle %0d: got %b expected 0", n, in_ready); end
    end
    in_valid = 1'b0;
    for (int n = 0; n < 20 && out_valid !== 1'b1; n++) tick();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL toggle_timeout: got out_valid=%b expected 1", out_valid); end
    e = sb.pop_front();
    $display("[TB] toggle block: out=%h latency=%0d", out_data, cyc - e.acc);
    tests++; if (out_data !== e.data) begin fails++; $display("FAIL toggle_data: got %h expected %h", out_data, e.data); end
    tests++; if (cyc - e.acc != e.nr + 1) begin fails++; $display("FAIL toggle_latency: got %0d expected %0d", cyc - e.acc, e.nr + 1); end
    tick();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    sb.delete();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = CT1;
    sb.push_back('{PT, cyc + 1, 10});
    tick();
    in_valid = 1'b0;
    for (int n = 0; n < 20 && kidx !== 4'd5; n++) tick();
    tests++; if (kidx !== 4'd5) begin fails++; $display("FAIL rstmid_reach: got key_idx=%0d expected 5", kidx); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 128'h0 || kidx !== 4'd0 || busy !== 1'b0) begin
      fails++; $display("FAIL rstmid_state: got in_ready=%b out_valid=%b out_data=%h key_idx=%0d busy=%b expected 1/0/0/0/0",
                        in_ready, out_valid, out_data, kidx, busy);
    end
    in_valid = 1'b1; in_data = CT1;
    sb.push_back('{PT, cyc + 1, 10});
    tick();
    in_valid = 1'b0;
    for (int n = 0; n < 20 && out_valid !== 1'b1; n++) tick();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rstmid_timeout: got out_valid=%b expected 1", out_valid); end
    e = sb.pop_front();
    $display("[TB] post-reset block: out=%h latency=%0d", out_data, cyc - e.acc);
    tests++; if (out_data !== e.data) begin fails++; $display("FAIL rstmid_data: got %h expected %h", out_data, e.data); end
    tests++; if (cyc - e.acc != e.nr + 1) begin fails++; $display("FAIL rstmid_latency: got %0d expected %0d", cyc - e.acc, e.nr + 1); end
    tick();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int nacc, nout, last_out;
    sb.delete();
    nacc = 0; nout = 0; last_out = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = CT1;
    for (int n = 0; n < 80 && nout < 3; n++) begin
      if (out_valid === 1'b1) begin
        tests++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL b2b_unexpected: got output %h expected none", out_data);
        end else begin
          e = sb.pop_front();
          $display("[TB] b2b block %0d: out=%h latency=%0d", nout, out_data, cyc - e.acc);
          tests++; if (out_data !== e.data) begin fails++; $display("FAIL b2b_data %0d: got %h expected %h", nout, out_data, e.data); end
          tests++; if (cyc - e.acc != e.nr + 1) begin fails++; $display("FAIL b2b_latency %0d: got %0d expected %0d", nout, cyc - e.acc, e.nr + 1); end
        end
        if (nout > 0) begin
          tests++; if (cyc - last_out != 13) begin fails++; $display("FAIL b2b_spacing %0d: got %0d expected 13", nout, cyc - last_out); end
        end
        last_out = cyc;
        nout++;
      end
      if (in_ready === 1'b1 && in_valid === 1'b1) begin
        sb.push_back('{PT, cyc + 1, 10});
        nacc++;
      end
      tick();
      if (nacc == 3) in_valid = 1'b0;
    end
    tests++; if (nout != 3) begin fails++; $display("FAIL b2b_count: got %0d outputs expected 3", nout); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));
    for (int r = 0; r < 16; r++) begin
      ks10[r] = (r <= 10) ? round_key_of(K1, 4, r) : '0;
      ks12[r] = (r <= 12) ? round_key_of(K2, 6, r) : '0;
      ks14[r] = (r <= 14) ? round_key_of(K3, 8, r) : '0;
    end
    test_reset();
    test_c1_trace();
    test_nr12();
    test_nr14();
    test_backpressure();
    test_in_valid_toggle();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time %0t expected the run to end earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
